// File: rtl/upsample_pkg.sv
// Shared types and constants for the 2x up-sampling read sequencer.
package upsample_pkg;

  localparam int DATA_W  = 8;
  localparam int COL_DEF = 800;
  localparam int ROW_DEF = 600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2
  } state_e;

  // Counter width that stays at least one bit for a single-row frame.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsample_pos_counter.sv
// Column/row position counter pair: column wraps at COL-1, row steps on a
// column wrap when enabled and wraps at ROW-1.
module upsample_pos_counter
  import upsample_pkg::*;
#(
  parameter int COL = COL_DEF,
  parameter int ROW = ROW_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  col_en_i,
  input  logic                  row_en_i,
  output logic [cnt_w(COL)-1:0] col_o,
  output logic                  col_last_o,
  output logic                  row_last_o
);

  localparam int COL_W = cnt_w(COL);
  localparam int ROW_W = cnt_w(ROW);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign col_last_o = (col_q == COL_MAX);
  assign row_last_o = (row_q == ROW_MAX);
  assign col_o      = col_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (col_en_i) begin
      if (col_last_o) begin
        col_d = '0;
        if (row_en_i) begin
          row_d = row_last_o ? '0 : row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/upsample_read_ctrl.sv
// Read-side sequencer: each source row is emitted from the FIFO, then replayed
// from the line shift register. Optional macro: UPSAMPLE_HDUP_EN (pixel doubling).
module upsample_read_ctrl
  import upsample_pkg::*;
#(
  parameter int COL = COL_DEF,
  parameter int ROW = ROW_DEF
) (
  input  logic              Ext_Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] line_q,
  output logic              line_ce,
  output logic [DATA_W-1:0] line_d,
  output logic              line_sclr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = cnt_w(COL);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col;
  logic              col_last, row_last;
  logic              src_avail, slot_free, load, advance, frame_start;
  logic [DATA_W-1:0] src_pix;
  logic              sol_d, eol_d, eof_d;

  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_sol_q, out_eol_q, out_eof_q;

`ifdef UPSAMPLE_HDUP_EN
  logic dup_q;
`endif

  upsample_pos_counter #(
    .COL(COL),
    .ROW(ROW)
  ) u_pos (
    .clk_i     (Ext_Clk),
    .rst_i     (Reset),
    .clr_i     (frame_start),
    .col_en_i  (advance),
    .row_en_i  (state_q == PASS2),
    .col_o     (col),
    .col_last_o(col_last),
    .row_last_o(row_last)
  );

  always_comb begin
    src_avail = 1'b0;
    src_pix   = fifo_dout;
    case (state_q)
      PASS1:   src_avail = !fifo_empty;
      PASS2: begin
        src_avail = 1'b1;
        src_pix   = line_q;
      end
      default: src_avail = 1'b0;
    endcase
  end

  assign slot_free   = !out_valid_q || out_ready;
  assign load        = slot_free && src_avail;
  assign frame_start = (state_q == IDLE) && start;

  // Position only moves once a pixel has been fully emitted.
`ifdef UPSAMPLE_HDUP_EN
  assign advance = load && dup_q;
  assign sol_d   = (col == '0) && !dup_q;
  assign eol_d   = col_last && dup_q;
`else
  assign advance = load;
  assign sol_d   = (col == '0);
  assign eol_d   = col_last;
`endif
  assign eof_d = eol_d && (state_q == PASS2) && row_last;

  assign fifo_rd_en = advance && (state_q == PASS1) && !Reset;
  assign line_ce    = advance && !Reset;
  assign line_d     = src_pix;
  assign line_sclr  = Reset || frame_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = PASS1;
      PASS1: if (advance && col_last) state_d = PASS2;
      PASS2: if (advance && col_last) state_d = row_last ? IDLE : PASS1;
      default: state_d = IDLE;
    endcase
  end

  // Output register stage: loads a pixel whenever the slot frees up.
  always_ff @(posedge Ext_Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= src_pix;
        out_sol_q   <= sol_d;
        out_eol_q   <= eol_d;
        out_eof_q   <= eof_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef UPSAMPLE_HDUP_EN
  always_ff @(posedge Ext_Clk) begin
    if (Reset || frame_start) begin
      dup_q <= 1'b0;
    end else if (load) begin
      dup_q <= !dup_q;
    end
  end
`endif

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sol    = out_sol_q;
  assign out_eol    = out_eol_q;
  assign out_eof    = out_eof_q;
  assign busy       = (state_q != IDLE) || out_valid_q;
  assign frame_done = out_valid_q && out_ready && out_eof_q && !Reset;

endmodule

// File: tb/tb_upsample_read_ctrl.sv
// Directed bench for upsample_read_ctrl with FIFO and line-register models.
module tb_upsample_read_ctrl;

`ifdef UPSAMPLE_HDUP_EN
  localparam int COL  = 2;
  localparam int ROW  = 1;
  localparam int NPIX = 8;
`else
  localparam int COL  = 4;
  localparam int ROW  = 2;
  localparam int NPIX = 16;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       eol;
    logic       eof;
  } vec_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       fifo_empty, fifo_rd_en;
  logic [7:0] fifo_dout, line_q, line_d, out_data;
  logic       line_ce, line_sclr, out_valid;
  logic       out_ready = 1'b1;
  logic       out_sol, out_eol, out_eof, busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  upsample_read_ctrl #(.COL(COL), .ROW(ROW)) dut (
    .Ext_Clk   (clk),
    .Reset     (Reset),
    .start     (start),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .line_q    (line_q),
    .line_ce   (line_ce),
    .line_d    (line_d),
    .line_sclr (line_sclr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Show-ahead FIFO model with an optional 5-cycle empty window at one entry.
  logic [7:0] mem [0:15];
  int wr_cnt = 0;
  int rd_ptr = 0;
  int empty_at = 99;
  int stall_cnt = 0;
  logic fifo_reload = 1'b1;

  assign fifo_empty = (rd_ptr >= wr_cnt) || (rd_ptr == empty_at && stall_cnt < 5);
  assign fifo_dout  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_reload) begin
      rd_ptr    <= 0;
      stall_cnt <= 0;
    end else begin
      if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
      if (rd_ptr == empty_at && stall_cnt < 5) stall_cnt <= stall_cnt + 1;
    end
  end

  // Line shift register model: shift in at [0], oldest tap at [COL-1].
  logic [7:0] lr [0:COL-1];
  assign line_q = lr[COL-1];

  always @(posedge clk) begin
    if (line_sclr) begin
      for (int i = 0; i < COL; i++) lr[i] <= 8'd0;
    end else if (line_ce) begin
      lr[0] <= line_d;
      for (int i = 1; i < COL; i++) lr[i] <= lr[i-1];
    end
  end

  // Output capture, sampled on the falling edge.
  logic [10:0] cap_d [0:31];
  int   cap_n = 0;
  int   fd_cnt = 0;
  int   fd_at = -1;
  int   gap = 0;
  logic cap_clr = 1'b1;

  always @(negedge clk) begin
    if (cap_clr) begin
      cap_n  <= 0;
      fd_cnt <= 0;
      fd_at  <= -1;
      gap    <= 0;
    end else if (!Reset) begin
      if (out_valid && out_ready) begin
        if (cap_n < 32) cap_d[cap_n] <= {out_data, out_sol, out_eol, out_eof};
        cap_n <= cap_n + 1;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_at  <= cap_n;
      end
      if (busy && !out_valid && cap_n > 0) gap <= gap + 1;
    end
  end

  vec_t tab [0:NPIX-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_clr = 1'b1;
    tick();
    cap_clr = 1'b0;
  endtask

  task automatic load_fifo(input int n, input int base0, input int base1);
    for (int i = 0; i < n; i++) mem[i] = 8'((i < COL) ? base0 + i : base1 + i - COL);
    wr_cnt = n;
    fifo_reload = 1'b1;
    tick();
    fifo_reload = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cap(input int n, input string nm);
    int t;
    t = 0;
    while (cap_n < n && t < 200) begin
      tick();
      t++;
    end
    if (cap_n < n) chk({nm, "_timeout"}, 32'(cap_n), 32'(n));
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (fd_cnt == 0 && t < 300) begin
      tick();
      t++;
    end
    if (fd_cnt == 0) chk({nm, "_timeout"}, 0, 1);
    tick();
    tick();
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, 32'(cap_n), 32'(NPIX));
    chk({tag, "_done_cnt"}, 32'(fd_cnt), 1);
    chk({tag, "_done_at"}, 32'(fd_at), 32'(NPIX - 1));
    chk({tag, "_busy_end"}, 32'(busy), 0);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_px[%0d]", tag, i), 32'(cap_d[i]), 32'(tab[i]));
  endtask

  initial begin
`ifdef UPSAMPLE_HDUP_EN
    tab[0] = '{8'd5, 1'b1, 1'b0, 1'b0};
    tab[1] = '{8'd5, 1'b0, 1'b0, 1'b0};
    tab[2] = '{8'd6, 1'b0, 1'b0, 1'b0};
    tab[3] = '{8'd6, 1'b0, 1'b1, 1'b0};
    tab[4] = '{8'd5, 1'b1, 1'b0, 1'b0};
    tab[5] = '{8'd5, 1'b0, 1'b0, 1'b0};
    tab[6] = '{8'd6, 1'b0, 1'b0, 1'b0};
    tab[7] = '{8'd6, 1'b0, 1'b1, 1'b1};
`else
    tab[0]  = '{8'd10, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{8'd11, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{8'd12, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{8'd13, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{8'd10, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{8'd11, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{8'd12, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{8'd13, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{8'd20, 1'b1, 1'b0, 1'b0};
    tab[9]  = '{8'd21, 1'b0, 1'b0, 1'b0};
    tab[10] = '{8'd22, 1'b0, 1'b0, 1'b0};
    tab[11] = '{8'd23, 1'b0, 1'b1, 1'b0};
    tab[12] = '{8'd20, 1'b1, 1'b0, 1'b0};
    tab[13] = '{8'd21, 1'b0, 1'b0, 1'b0};
    tab[14] = '{8'd22, 1'b0, 1'b0, 1'b0};
    tab[15] = '{8'd23, 1'b0, 1'b1, 1'b1};
`endif

    repeat (3) tick();
    @(negedge clk);
    chk("rst_sclr", 32'(line_sclr), 1);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_line_ce", 32'(line_ce), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_flags", 32'({out_sol, out_eol, out_eof}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    tick();
    Reset = 1'b0;
    fifo_reload = 1'b0;
    cap_clr = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

`ifdef UPSAMPLE_HDUP_EN
    clear_cap();
    load_fifo(2, 5, 5);
    pulse_start();
    wait_done("hdup");
    check_frame("hdup");
    chk("hdup_pops", 32'(rd_ptr), 2);
    chk("hdup_gap", 32'(gap), 0);
`else
    // Plain frame at full throughput.
    clear_cap();
    load_fifo(8, 10, 20);
    pulse_start();
    wait_done("t1");
    check_frame("t1");
    chk("t1_gap", 32'(gap), 0);
    chk("t1_pops", 32'(rd_ptr), 8);

    // Back-pressure on the sixth output pixel (PASS2, value 11).
    clear_cap();
    load_fifo(8, 10, 20);
    pulse_start();
    wait_cap(5, "t2");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t2_valid[%0d]", k), 32'(out_valid), 1);
      chk($sformatf("t2_data[%0d]", k), 32'(out_data), 11);
      chk($sformatf("t2_rd_en[%0d]", k), 32'(fifo_rd_en), 0);
      chk($sformatf("t2_line_ce[%0d]", k), 32'(line_ce), 0);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t2");
    check_frame("t2");

    // FIFO empty for 5 cycles with 13 at the head.
    clear_cap();
    empty_at = 3;
    load_fifo(8, 10, 20);
    pulse_start();
    wait_done("t3");
    empty_at = 99;
    check_frame("t3");
    chk("t3_gap", 32'(gap), 5);

    // start during PASS1 is ignored.
    clear_cap();
    load_fifo(8, 10, 20);
    pulse_start();
    wait_cap(2, "t4");
    pulse_start();
    wait_done("t4");
    check_frame("t4");
    repeat (5) tick();
    chk("t4_no_rerun", 32'(busy), 0);
    chk("t4_count_after", 32'(cap_n), 16);

    // Reset in PASS2 row 0 col 2, then restart from the FIFO head.
    clear_cap();
    load_fifo(8, 10, 20);
    pulse_start();
    wait_cap(5, "t5");
    Reset = 1'b1;
    @(negedge clk);
    chk("t5_rd_en", 32'(fifo_rd_en), 0);
    chk("t5_line_ce", 32'(line_ce), 0);
    chk("t5_sclr", 32'(line_sclr), 1);
    chk("t5_done", 32'(frame_done), 0);
    tick();
    Reset = 1'b0;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_pops", 32'(rd_ptr), 4);
    clear_cap();
    pulse_start();
    wait_cap(1, "t5r");
    chk("t5_restart_px", 32'(cap_d[0]), 32'({8'd20, 1'b1, 1'b0, 1'b0}));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("t5_final_busy", 32'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
